// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  // Load sequencing: two header bytes, the data words, the checksum byte,
  // then a terminal outcome that holds until restart or reset.
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 16;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in
// bits [31:24]. The word is presented combinationally together with its
// fourth byte so the caller can register it on the same handshake.
module byte_packer
  import loader_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] r_byte_idx;
  logic [23:0]      r_shift;

  assign o_word_valid = i_byte_en & (r_byte_idx == LAST_IDX);
  assign o_word       = {r_shift, i_byte};

  // Shift accepted bytes in MSB-first and wrap the byte counter per word.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_byte_idx <= '0;
      r_shift    <= 24'h00_0000;
    end else if (i_clear) begin
      r_byte_idx <= '0;
      r_shift    <= 24'h00_0000;
    end else if (i_byte_en) begin
      r_shift    <= {r_shift[15:0], i_byte};
      r_byte_idx <= o_word_valid ? '0 : r_byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Parses a length-prefixed byte
// stream, writes each assembled word, checks an XOR checksum over the
// data bytes and keeps the CPU held until a load finishes cleanly.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = HDR_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
  // One extra bit so the oversize compare cannot wrap.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH_WORDS);

  state_e            r_state, w_state_n;
  logic [CNT_W-1:0]  r_count, w_count_n;
  logic [IDX_W-1:0]  r_word_idx, w_word_idx_n;
  logic [7:0]        r_csum, w_csum_n;
  logic              r_we, w_we_n;
  logic [31:0]       r_addr, w_addr_n;
  logic [31:0]       r_wdata, w_wdata_n;
  logic              r_hold, w_hold_n;
  logic              r_done, w_done_n;
  logic              r_error, w_error_n;

  logic              w_hs;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [CNT_W-1:0]  w_count_lo;
  logic [IDX_W-1:0]  w_idx_inc;

  assign in_ready   = (r_state == LEN_HI) | (r_state == LEN_LO) |
                      (r_state == DATA)   | (r_state == CHK);
  // A restart in the same cycle wins and the byte is left unconsumed.
  assign w_hs       = in_valid & in_ready & ~restart;
  assign w_count_lo = {r_count[CNT_W-1:8], in_data};
  assign w_idx_inc  = r_word_idx + 1'b1;

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign error      = r_error;

  byte_packer u_packer (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_clear      (restart),
    .i_byte_en    (w_hs & (r_state == DATA)),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State, counters and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= LEN_HI;
      r_count    <= '0;
      r_word_idx <= '0;
      r_csum     <= 8'h00;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 32'h0000_0000;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_count    <= w_count_n;
      r_word_idx <= w_word_idx_n;
      r_csum     <= w_csum_n;
      r_we       <= w_we_n;
      r_addr     <= w_addr_n;
      r_wdata    <= w_wdata_n;
      r_hold     <= w_hold_n;
      r_done     <= w_done_n;
      r_error    <= w_error_n;
    end
  end

  // Next-state and next-output decode; everything moves only on a handshake.
  always_comb begin
    w_state_n    = r_state;
    w_count_n    = r_count;
    w_word_idx_n = r_word_idx;
    w_csum_n     = r_csum;
    w_we_n       = 1'b0;
    w_addr_n     = r_addr;
    w_wdata_n    = r_wdata;
    w_hold_n     = r_hold;
    w_done_n     = r_done;
    w_error_n    = r_error;

    if (restart) begin
      w_state_n    = LEN_HI;
      w_count_n    = '0;
      w_word_idx_n = '0;
      w_csum_n     = 8'h00;
      w_hold_n     = 1'b1;
      w_done_n     = 1'b0;
      w_error_n    = 1'b0;
    end else if (w_hs) begin
      case (r_state)
        LEN_HI: begin
          w_count_n = CNT_W'({in_data, 8'h00});
          w_state_n = LEN_LO;
        end
        LEN_LO: begin
          w_count_n = w_count_lo;
          if (w_count_lo == '0) begin
            w_state_n = CHK;
          end else if ({1'b0, w_count_lo} > DEPTH_C) begin
            w_state_n = ERR;
            w_error_n = 1'b1;
          end else begin
            w_state_n = DATA;
          end
        end
        DATA: begin
          w_csum_n = r_csum ^ in_data;
          if (w_word_valid) begin
            w_we_n       = 1'b1;
            w_wdata_n    = w_word;
            w_addr_n     = BASE_ADDR + (32'(r_word_idx) << 2);
            w_word_idx_n = w_idx_inc;
            if (CNT_W'(w_idx_inc) == r_count) begin
              w_state_n = CHK;
            end
          end
        end
        CHK: begin
          if (in_data == r_csum) begin
            w_state_n = DONE;
            w_done_n  = 1'b1;
            w_hold_n  = 1'b0;
          end else begin
            w_state_n = ERR;
            w_error_n = 1'b1;
          end
        end
        default: begin
          w_state_n = r_state;
        end
      endcase
    end
  end

endmodule
